// File: rtl/lx32_mmio_pkg.sv
// Shared definitions for the LX32 data-memory responder: MMIO addresses,
// STATUS bit positions and the address-region decode.
package lx32_mmio_pkg;

  localparam int unsigned XLEN = 32;

  // MMIO register word addresses (byte offset bits [1:0] are ignored)
  localparam logic [XLEN-1:0] ADDR_TX_DATA  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ADDR_STATUS   = 32'h8000_0004;
  localparam logic [XLEN-1:0] ADDR_MTIME    = 32'h8000_0008;
  localparam logic [XLEN-1:0] ADDR_MTIMECMP = 32'h8000_000C;

  // STATUS register bit positions
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;

  // Reset value of MTIMECMP keeps the timer interrupt quiet
  localparam logic [XLEN-1:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_TX_DATA,
    REGION_STATUS,
    REGION_MTIME,
    REGION_MTIMECMP,
    REGION_UNMAPPED
  } region_e;

  // Classify a byte address; RAM spans [0, 2**ram_bytes_log2)
  function automatic region_e decode_region(input logic [XLEN-1:0] addr,
                                            input int unsigned     ram_bytes_log2);
    logic [XLEN-1:0] word_addr;
    region_e         region;
    word_addr = {addr[XLEN-1:2], 2'b00};
    region    = REGION_UNMAPPED;
    if ((word_addr >> ram_bytes_log2) == '0) begin
      region = REGION_RAM;
    end else begin
      case (word_addr)
        ADDR_TX_DATA:  region = REGION_TX_DATA;
        ADDR_STATUS:   region = REGION_STATUS;
        ADDR_MTIME:    region = REGION_MTIME;
        ADDR_MTIMECMP: region = REGION_MTIMECMP;
        default:       region = REGION_UNMAPPED;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/lx32_sync_fifo.sv
// Synchronous FIFO with registered storage and no fall-through.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (empties the FIFO)
//   push_i, data_i    - write request and data; accepted when not full, or
//                       when full and a pop happens in the same cycle
//   pop_i             - read request; ignored when empty
//   data_o            - head entry, zero while empty
//   full_o, empty_o   - occupancy flags
module lx32_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the simultaneous push needs
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer/count next state; power-of-two depth makes pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_push && rst_n) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/lx32_dmem_responder.sv
// Data-side memory responder for the single-cycle LX32 core: word RAM,
// console TX FIFO, STATUS register and a machine timer.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   mem_addr, mem_wdata - byte address and store data from the core
//   mem_we              - store strobe, committed at the rising edge
//   mem_rdata           - zero-latency load data
//   tx_valid, tx_data   - console byte stream (FIFO head)
//   tx_ready            - consumer accepts the head byte
//   timer_irq           - level interrupt, MTIME >= MTIMECMP
module lx32_dmem_responder
  import lx32_mmio_pkg::*;
#(
  parameter int unsigned DMEM_WORDS    = 1024,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned RAM_IDX_W      = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned RAM_BYTES_LOG2 = RAM_IDX_W + 2;
  localparam int unsigned TX_W           = 8;

  region_e              region;
  logic                 wr_en;
  logic [RAM_IDX_W-1:0] ram_idx;
  logic [31:0]          ram_q [DMEM_WORDS];

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [31:0]          mtime_q, mtime_d;
  logic [31:0]          mtimecmp_q, mtimecmp_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          status_word;

  assign region  = decode_region(mem_addr, RAM_BYTES_LOG2);
  // Stores are ignored while reset is asserted
  assign wr_en   = mem_we && rst_n;
  assign ram_idx = mem_addr[RAM_IDX_W+1:2];

  // Word RAM: synchronous write, asynchronous read, never reset
  always_ff @(posedge clk) begin
    if (wr_en && (region == REGION_RAM)) ram_q[ram_idx] <= mem_wdata;
  end

  assign fifo_push = wr_en && (region == REGION_TX_DATA);
  assign fifo_pop  = tx_valid && tx_ready && rst_n;
  assign tx_valid  = !fifo_empty;

  lx32_sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (mem_wdata[TX_W-1:0]),
    .pop_i   (fifo_pop),
    .data_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Timer, compare and sticky overflow next state
  always_comb begin
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    overflow_d = overflow_q;
    if (wr_en && (region == REGION_MTIMECMP)) mtimecmp_d = mtime_wdata_passthru(mem_wdata);
    // A push into a full FIFO is lost only when nothing drains this cycle
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    if (wr_en && (region == REGION_STATUS) && mem_wdata[STATUS_OVF_BIT]) overflow_d = 1'b0;
  end

  function automatic logic [31:0] mtime_wdata_passthru(input logic [31:0] d);
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      overflow_q <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      overflow_q <= overflow_d;
    end
  end

  // Compare of registered values only, so no path from the bus
  assign timer_irq = (mtime_q >= mtimecmp_q);

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_OVF_BIT]   = overflow_q;
  end

  // Zero-latency load mux; TX_DATA and unmapped space read as zero
  always_comb begin
    mem_rdata = '0;
    case (region)
      REGION_RAM:      mem_rdata = ram_q[ram_idx];
      REGION_STATUS:   mem_rdata = status_word;
      REGION_MTIME:    mem_rdata = mtime_q;
      REGION_MTIMECMP: mem_rdata = mtimecmp_q;
      default:         mem_rdata = '0;
    endcase
  end

endmodule
